// File: rtl/arp_pkg.sv
// Shared types and constants for the next-hop MAC resolver.
package arp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEEK,
      ST_WAIT,
      ST_ARP_REQ,
      ST_ARP_WAIT,
      ST_DONE,
      ST_FAIL
   } state_t;

   // An all-ones MAC from the ARP table means "not present"; it is also
   // what we hand to the framer for broadcast destinations and failures.
   localparam logic [47:0] C_MAC_BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] C_IP_BCAST  = 32'hFFFF_FFFF;

endpackage

// File: rtl/arp_timeout_cnt.sv
// Saturating timeout counter: tc pulses on the last enabled cycle of a
// P_TO-cycle window that starts after clear drops.
module arp_timeout_cnt #(
   parameter int P_TO = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int W = $clog2(P_TO + 1);
   localparam logic [W-1:0] C_LAST = W'(P_TO - 1);
   localparam logic [W-1:0] C_SAT  = W'(P_TO);

   logic [W-1:0] count;

   // Count enabled cycles, holding at P_TO instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != C_SAT)) begin
         count <= count + 1'b1;
      end
   end

   assign tc = enable && (count == C_LAST);

endmodule

// File: rtl/arp_mac_resolver.sv
// Next-hop MAC resolver: looks up the destination IP in the ARP table,
// falls back to ARP requests with retry, and reports a MAC or a failure.
module arp_mac_resolver
   import arp_pkg::*;
#(
   parameter int P_LOOKUP_TO = 32,
   parameter int P_REPLY_TO  = 125000,
   parameter int P_MAX_RETRY = 3
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_req_ip,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   output logic [31:0] o_seek_ip,
   output logic        o_seek_valid,
   input  logic [47:0] i_active_mac,
   input  logic        i_active_valid,
   input  logic [31:0] i_updata_ip,
   input  logic [47:0] i_updata_mac,
   input  logic        i_updata_valid,
   output logic [31:0] o_arp_req_ip,
   output logic        o_arp_req_valid,
   input  logic        i_arp_req_ready,
   output logic [47:0] o_dst_mac,
   output logic        o_dst_valid,
   output logic        o_dst_fail
);

   localparam int RW = $clog2(P_MAX_RETRY + 1);
   localparam logic [RW-1:0] C_MAX_RETRY = RW'(P_MAX_RETRY);

   state_t          state;
   logic [31:0]     req_ip;
   logic [RW-1:0]   retry_cnt;
   logic            lookup_clear;
   logic            lookup_en;
   logic            lookup_tc;
   logic            reply_clear;
   logic            reply_en;
   logic            reply_tc;
   logic            upd_match;

   // Each timer only runs while we sit in its waiting state and restarts
   // from zero every time that state is entered.
   assign lookup_en    = (state == ST_WAIT);
   assign lookup_clear = !lookup_en;
   assign reply_en     = (state == ST_ARP_WAIT);
   assign reply_clear  = !reply_en;

   assign upd_match = i_updata_valid && (i_updata_ip == req_ip);

   arp_timeout_cnt #(.P_TO(P_LOOKUP_TO)) u_lookup_to (
      .clk    (i_clk),
      .rst    (i_rst),
      .clear  (lookup_clear),
      .enable (lookup_en),
      .tc     (lookup_tc)
   );

   arp_timeout_cnt #(.P_TO(P_REPLY_TO)) u_reply_to (
      .clk    (i_clk),
      .rst    (i_rst),
      .clear  (reply_clear),
      .enable (reply_en),
      .tc     (reply_tc)
   );

   // Resolution FSM; every output is registered and is set on the edge
   // that enters the state which owns it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= ST_IDLE;
         req_ip          <= '0;
         retry_cnt       <= '0;
         o_req_ready     <= 1'b0;
         o_seek_ip       <= '0;
         o_seek_valid    <= 1'b0;
         o_arp_req_ip    <= '0;
         o_arp_req_valid <= 1'b0;
         o_dst_mac       <= '0;
         o_dst_valid     <= 1'b0;
         o_dst_fail      <= 1'b0;
      end else begin
         o_seek_valid <= 1'b0;
         o_dst_valid  <= 1'b0;
         o_dst_fail   <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_req_ready <= 1'b1;
               retry_cnt   <= '0;
               if (i_req_valid && o_req_ready) begin
                  o_req_ready <= 1'b0;
                  req_ip      <= i_req_ip;
                  if (i_req_ip == C_IP_BCAST) begin
                     state       <= ST_DONE;
                     o_dst_valid <= 1'b1;
                     o_dst_mac   <= C_MAC_BCAST;
                  end else begin
                     state        <= ST_SEEK;
                     o_seek_valid <= 1'b1;
                     o_seek_ip    <= i_req_ip;
                  end
               end
            end
            ST_SEEK: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_active_valid && (i_active_mac != C_MAC_BCAST)) begin
                  state       <= ST_DONE;
                  o_dst_valid <= 1'b1;
                  o_dst_mac   <= i_active_mac;
               end else if (upd_match) begin
                  state       <= ST_DONE;
                  o_dst_valid <= 1'b1;
                  o_dst_mac   <= i_updata_mac;
               end else if (i_active_valid || lookup_tc) begin
                  state           <= ST_ARP_REQ;
                  o_arp_req_valid <= 1'b1;
                  o_arp_req_ip    <= req_ip;
               end
            end
            ST_ARP_REQ: begin
               if (upd_match) begin
                  state           <= ST_DONE;
                  o_arp_req_valid <= 1'b0;
                  o_dst_valid     <= 1'b1;
                  o_dst_mac       <= i_updata_mac;
               end else if (i_arp_req_ready) begin
                  state           <= ST_ARP_WAIT;
                  o_arp_req_valid <= 1'b0;
                  if (retry_cnt != C_MAX_RETRY) begin
                     retry_cnt <= retry_cnt + 1'b1;
                  end
               end
            end
            ST_ARP_WAIT: begin
               if (upd_match) begin
                  state       <= ST_DONE;
                  o_dst_valid <= 1'b1;
                  o_dst_mac   <= i_updata_mac;
               end else if (reply_tc) begin
                  if (retry_cnt < C_MAX_RETRY) begin
                     state           <= ST_ARP_REQ;
                     o_arp_req_valid <= 1'b1;
                     o_arp_req_ip    <= req_ip;
                  end else begin
                     state       <= ST_FAIL;
                     o_dst_valid <= 1'b1;
                     o_dst_fail  <= 1'b1;
                     o_dst_mac   <= C_MAC_BCAST;
                  end
               end
            end
            ST_DONE: begin
               state       <= ST_IDLE;
               o_req_ready <= 1'b1;
            end
            ST_FAIL: begin
               state       <= ST_IDLE;
               o_req_ready <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arp_mac_resolver.sv
// Self-checking bench for arp_mac_resolver: a vector table of complete
// resolutions plus hand-written sequences for reset and snoop corner cases.
module tb_arp_mac_resolver;

   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic        clk;
   logic        i_rst;
   logic [31:0] i_req_ip;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] o_seek_ip;
   logic        o_seek_valid;
   logic [47:0] i_active_mac;
   logic        i_active_valid;
   logic [31:0] i_updata_ip;
   logic [47:0] i_updata_mac;
   logic        i_updata_valid;
   logic [31:0] o_arp_req_ip;
   logic        o_arp_req_valid;
   logic        i_arp_req_ready;
   logic [47:0] o_dst_mac;
   logic        o_dst_valid;
   logic        o_dst_fail;

   int checks = 0;
   int errors = 0;

   arp_mac_resolver #(
      .P_LOOKUP_TO (32),
      .P_REPLY_TO  (100),
      .P_MAX_RETRY (3)
   ) dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .i_req_ip        (i_req_ip),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .o_seek_ip       (o_seek_ip),
      .o_seek_valid    (o_seek_valid),
      .i_active_mac    (i_active_mac),
      .i_active_valid  (i_active_valid),
      .i_updata_ip     (i_updata_ip),
      .i_updata_mac    (i_updata_mac),
      .i_updata_valid  (i_updata_valid),
      .o_arp_req_ip    (o_arp_req_ip),
      .o_arp_req_valid (o_arp_req_valid),
      .i_arp_req_ready (i_arp_req_ready),
      .o_dst_mac       (o_dst_mac),
      .o_dst_valid     (o_dst_valid),
      .o_dst_fail      (o_dst_fail)
   );

   // 100 MHz bench clock; inputs change and outputs are sampled on negedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One resolution: how the table and ARP RX behave, and what must come out.
   // Latency fields count negedges after the accept edge (-1 = not checked).
   typedef struct {
      string       name;
      logic [31:0] ip;
      bit          active_resp;
      logic [47:0] table_mac;
      bit          reply_en;
      logic [47:0] reply_mac;
      logic [47:0] exp_mac;
      bit          exp_fail;
      int          exp_seeks;
      int          exp_arps;
      int          exp_lat;
      int          exp_first_arp;
      int          exp_gap;
   } vec_t;

   task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      i_req_valid     = 1'b0;
      i_active_valid  = 1'b0;
      i_updata_valid  = 1'b0;
      i_arp_req_ready = 1'b0;
   endtask

   task automatic sendRequest(input logic [31:0] ip);
      int w;
      w = 0;
      while (!o_req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      checkOutput("req_ready_before_request", {47'd0, o_req_ready}, 48'd1);
      i_req_ip    = ip;
      i_req_valid = 1'b1;
      @(negedge clk);
      i_req_valid = 1'b0;
   endtask

   task automatic waitArpValid(input string name);
      for (int k = 0; k < 100 && !o_arp_req_valid; k++) @(negedge clk);
      checkOutput(name, {47'd0, o_arp_req_valid}, 48'd1);
   endtask

   // Plays table and ARP RX for one request until the result strobe.
   task automatic applyStimulus(input vec_t v, output logic [47:0] mac, output logic fail,
                                output int seeks, output int arps, output int lat,
                                output int first_arp, output int bad_gaps, output int ip_errs,
                                output bit done);
      int seek_at;
      int hs_at;
      mac = '0; fail = 1'b0; seeks = 0; arps = 0; lat = -1; first_arp = -1;
      bad_gaps = 0; ip_errs = 0; done = 1'b0; seek_at = -1; hs_at = -1;
      sendRequest(v.ip);
      for (int c = 0; c < 1000; c++) begin
         idleInputs();
         if (o_dst_valid) begin
            mac = o_dst_mac; fail = o_dst_fail; lat = c; done = 1'b1;
            break;
         end
         if (o_seek_valid) begin
            seeks++;
            seek_at = c;
            if (o_seek_ip !== v.ip) ip_errs++;
         end
         if (v.active_resp && seek_at >= 0 && c == seek_at + 2) begin
            i_active_valid = 1'b1;
            i_active_mac   = v.table_mac;
         end
         if (o_arp_req_valid) begin
            i_arp_req_ready = 1'b1;
            if (o_arp_req_ip !== v.ip) ip_errs++;
            if (arps == 0) first_arp = c;
            else if (v.exp_gap > 0 && (c - hs_at) != v.exp_gap) bad_gaps++;
            hs_at = c;
            arps++;
         end
         if (v.reply_en && hs_at >= 0 && c == hs_at + 3) begin
            i_updata_valid = 1'b1;
            i_updata_ip    = v.ip;
            i_updata_mac   = v.reply_mac;
         end
         @(negedge clk);
      end
      idleInputs();
   endtask

   vec_t vecs[6];

   initial begin
      logic [47:0] mac;
      logic        fail;
      int          seeks, arps, lat, first_arp, bad_gaps, ip_errs;
      bit          done;
      bit          saw_dst;

      vecs[0] = '{"hit", 32'hC0A8_010A, 1'b1, 48'h000A_3501_0203, 1'b0, 48'h0,
                  48'h000A_3501_0203, 1'b0, 1, 0, 3, -1, 0};
      vecs[1] = '{"miss_reply", 32'hC0A8_010A, 1'b1, BCAST, 1'b1, 48'h1122_3344_5566,
                  48'h1122_3344_5566, 1'b0, 1, 1, 7, 3, 0};
      vecs[2] = '{"broadcast", 32'hFFFF_FFFF, 1'b1, 48'h0, 1'b0, 48'h0,
                  BCAST, 1'b0, 0, 0, 0, -1, 0};
      vecs[3] = '{"no_reply", 32'hC0A8_010B, 1'b1, BCAST, 1'b0, 48'h0,
                  BCAST, 1'b1, 1, 3, 306, 3, 101};
      vecs[4] = '{"lookup_timeout", 32'hC0A8_0114, 1'b0, 48'h0, 1'b1, 48'hA1A2_A3A4_A5A6,
                  48'hA1A2_A3A4_A5A6, 1'b0, 1, 1, 37, 33, 0};
      vecs[5] = '{"hit_other", 32'h0A00_0001, 1'b1, 48'hDEAD_BEEF_0001, 1'b0, 48'h0,
                  48'hDEAD_BEEF_0001, 1'b0, 1, 0, 3, -1, 0};

      idleInputs();
      i_req_ip = '0; i_active_mac = '0; i_updata_ip = '0; i_updata_mac = '0;
      i_rst = 1'b1;
      repeat (3) @(negedge clk);

      // Everything must be zero while reset is held, including req_ready.
      checkOutput("reset_outputs",
                  {o_req_ready, o_seek_valid, o_arp_req_valid, o_dst_valid, o_dst_fail, 43'd0},
                  48'd0);
      checkOutput("reset_dst_mac", o_dst_mac, 48'd0);
      i_rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", {47'd0, o_req_ready}, 48'd1);

      // Table-driven full resolutions.
      foreach (vecs[i]) begin
         applyStimulus(vecs[i], mac, fail, seeks, arps, lat, first_arp, bad_gaps, ip_errs, done);
         checkOutput({vecs[i].name, "_done"}, {47'd0, done}, 48'd1);
         checkOutput({vecs[i].name, "_mac"}, mac, vecs[i].exp_mac);
         checkOutput({vecs[i].name, "_fail"}, {47'd0, fail}, {47'd0, vecs[i].exp_fail});
         checkOutput({vecs[i].name, "_seeks"}, 48'(seeks), 48'(vecs[i].exp_seeks));
         checkOutput({vecs[i].name, "_arps"}, 48'(arps), 48'(vecs[i].exp_arps));
         checkOutput({vecs[i].name, "_ip"}, 48'(ip_errs), 48'd0);
         checkOutput({vecs[i].name, "_latency"}, 48'(lat), 48'(vecs[i].exp_lat));
         if (vecs[i].exp_first_arp >= 0)
            checkOutput({vecs[i].name, "_first_arp"}, 48'(first_arp), 48'(vecs[i].exp_first_arp));
         if (vecs[i].exp_gap > 0)
            checkOutput({vecs[i].name, "_arp_gap"}, 48'(bad_gaps), 48'd0);
         @(negedge clk);
         checkOutput({vecs[i].name, "_strobe_1cyc"}, {47'd0, o_dst_valid}, 48'd0);
         checkOutput({vecs[i].name, "_mac_hold"}, o_dst_mac, vecs[i].exp_mac);
         checkOutput({vecs[i].name, "_ready_next"}, {47'd0, o_req_ready}, 48'd1);
      end

      // ARP TX stalls: request must hold; foreign update and stray lookup
      // result are ignored in ARP_WAIT; matching update then resolves.
      sendRequest(32'h0A00_0002);
      waitArpValid("stall_arp_seen");
      bad_gaps = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (!o_arp_req_valid || o_arp_req_ip !== 32'h0A00_0002) bad_gaps++;
      end
      checkOutput("stall_holds_req", 48'(bad_gaps), 48'd0);
      i_arp_req_ready = 1'b1;
      @(negedge clk);
      i_arp_req_ready = 1'b0;
      checkOutput("stall_handshake_drop", {47'd0, o_arp_req_valid}, 48'd0);
      i_updata_valid = 1'b1; i_updata_ip = 32'h0A00_00FF; i_updata_mac = 48'h0101_0101_0101;
      i_active_valid = 1'b1; i_active_mac = 48'h0202_0202_0202;
      saw_dst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         idleInputs();
         if (o_dst_valid) saw_dst = 1'b1;
      end
      checkOutput("ignore_foreign_update", {47'd0, saw_dst}, 48'd0);
      i_updata_valid = 1'b1; i_updata_ip = 32'h0A00_0002; i_updata_mac = 48'h6655_4433_2211;
      @(negedge clk);
      idleInputs();
      checkOutput("late_reply_valid", {47'd0, o_dst_valid}, 48'd1);
      checkOutput("late_reply_mac", o_dst_mac, 48'h6655_4433_2211);

      // A matching update while the ARP request is still pending resolves
      // immediately and withdraws the request.
      sendRequest(32'h0A00_0004);
      waitArpValid("snoop_req_arp_seen");
      i_updata_valid = 1'b1; i_updata_ip = 32'h0A00_0004; i_updata_mac = 48'h0A0B_0C0D_0E0F;
      @(negedge clk);
      idleInputs();
      checkOutput("snoop_req_valid", {47'd0, o_dst_valid}, 48'd1);
      checkOutput("snoop_req_mac", o_dst_mac, 48'h0A0B_0C0D_0E0F);
      checkOutput("snoop_req_drop", {47'd0, o_arp_req_valid}, 48'd0);

      // Hit and matching update on the same WAIT cycle: the table MAC wins.
      sendRequest(32'h0A00_0005);
      checkOutput("both_seek", {47'd0, o_seek_valid}, 48'd1);
      @(negedge clk);
      i_active_valid = 1'b1; i_active_mac = 48'h0200_0000_0005;
      i_updata_valid = 1'b1; i_updata_ip = 32'h0A00_0005; i_updata_mac = 48'h0300_0000_0005;
      @(negedge clk);
      idleInputs();
      checkOutput("both_valid", {47'd0, o_dst_valid}, 48'd1);
      checkOutput("both_hit_wins", o_dst_mac, 48'h0200_0000_0005);

      // Reset during ARP_WAIT aborts silently; the next request works.
      sendRequest(32'h0A00_0003);
      @(negedge clk);
      i_active_valid = 1'b1; i_active_mac = BCAST;
      @(negedge clk);
      idleInputs();
      waitArpValid("rst_arp_seen");
      i_arp_req_ready = 1'b1;
      @(negedge clk);
      i_arp_req_ready = 1'b0;
      repeat (5) @(negedge clk);
      i_rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_outputs",
                  {o_req_ready, o_seek_valid, o_arp_req_valid, o_dst_valid, o_dst_fail, 43'd0},
                  48'd0);
      checkOutput("midrst_mac", o_dst_mac, 48'd0);
      @(negedge clk);
      i_rst = 1'b0;
      saw_dst = 1'b0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (o_dst_valid || o_arp_req_valid) saw_dst = 1'b1;
      end
      checkOutput("midrst_no_result", {47'd0, saw_dst}, 48'd0);
      applyStimulus(vecs[0], mac, fail, seeks, arps, lat, first_arp, bad_gaps, ip_errs, done);
      checkOutput("after_rst_done", {47'd0, done}, 48'd1);
      checkOutput("after_rst_mac", mac, 48'h000A_3501_0203);
      checkOutput("after_rst_fail", {47'd0, fail}, 48'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
